// File: rtl/axi_wr_slv.sv
// axi_wr_slv: AXI write-channel slave (AW/W/B) backed by an internal word memory.
//
// Accepts one write burst at a time. Each accepted W beat writes the byte lanes
// of mem[addr>>2] selected by WSTRB, unless the beat is in error. One B response
// is returned per burst. A combinational debug port reads the memory directly.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   axi_slv_aw*           write address channel (id/addr/len/size/burst/valid/ready)
//   axi_slv_w*            write data channel (data/strb/last/valid/ready)
//   axi_slv_b*            write response channel (id/resp/valid/ready)
//   dbg_addr / dbg_rdata  debug word index / combinational memory read data
module axi_wr_slv #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_WIDTH-1:0]          axi_slv_awid,
  input  logic [ADDR_WIDTH-1:0]        axi_slv_awaddr,
  input  logic [LEN_WIDTH-1:0]         axi_slv_awlen,
  input  logic [2:0]                   axi_slv_awsize,
  input  logic [1:0]                   axi_slv_awburst,
  input  logic                         axi_slv_awvalid,
  output logic                         axi_slv_awready,
  input  logic [DATA_WIDTH-1:0]        axi_slv_wdata,
  input  logic [DATA_WIDTH/8-1:0]      axi_slv_wstrb,
  input  logic                         axi_slv_wlast,
  input  logic                         axi_slv_wvalid,
  output logic                         axi_slv_wready,
  output logic [ID_WIDTH-1:0]          axi_slv_bid,
  output logic [1:0]                   axi_slv_bresp,
  output logic                         axi_slv_bvalid,
  input  logic                         axi_slv_bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);

  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Registered handshake outputs and their next values
  logic                  r_awready, w_awready_nxt;
  logic                  r_wready,  w_wready_nxt;
  logic                  r_bvalid,  w_bvalid_nxt;
  logic [ID_WIDTH-1:0]   r_bid,     w_bid_nxt;
  logic [1:0]            r_bresp,   w_bresp_nxt;

  // Captured AW fields and per-burst bookkeeping
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic                  r_cfg_err;    // illegal size/burst/wrap-len: no beat is written
  logic                  r_proto_err;  // wlast early or missing
  logic                  r_decerr;     // some beat fell outside the memory
  logic                  r_over;       // past beat len without wlast: discard until wlast

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_aw_cfg_err;
  logic                  w_wrap_len_ok;
  logic [ADDR_WIDTH-3:0] w_word;
  logic                  w_oor;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_beat_last;
  logic                  w_beat_oor_err;
  logic                  w_beat_wr;
  logic                  w_proto_now;
  logic                  w_slv_nxt;
  logic                  w_dec_nxt;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [ADDR_WIDTH-1:0] w_inc;
  logic [ADDR_WIDTH-1:0] w_wrap_bytes;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_wrap;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  assign w_aw_hs = r_awready & axi_slv_awvalid;
  assign w_w_hs  = r_wready  & axi_slv_wvalid;
  assign w_b_hs  = r_bvalid  & axi_slv_bready;

  assign w_wrap_len_ok = (axi_slv_awlen == LEN_WIDTH'(1)) || (axi_slv_awlen == LEN_WIDTH'(3)) ||
                         (axi_slv_awlen == LEN_WIDTH'(7)) || (axi_slv_awlen == LEN_WIDTH'(15));

  assign w_aw_cfg_err = (axi_slv_awsize > 3'd2) || (axi_slv_awburst == 2'b11) ||
                        ((axi_slv_awburst == BURST_WRAP) && !w_wrap_len_ok);

  // Word index of the current beat; any set bit above the index range is out of memory
  assign w_word = r_addr[ADDR_WIDTH-1:2];
  assign w_oor  = |w_word[ADDR_WIDTH-3:IDX_W];
  assign w_idx  = w_word[IDX_W-1:0];

  assign w_beat_last    = (r_beat == r_len);
  assign w_beat_oor_err = w_w_hs & ~r_over & w_oor;
  assign w_beat_wr      = w_w_hs & ~r_over & ~w_oor & ~r_cfg_err & ~rst;

  // wlast must coincide exactly with beat len; either mismatch is a protocol error
  assign w_proto_now = w_w_hs & ~r_over & (axi_slv_wlast ^ w_beat_last);

  assign w_slv_nxt = r_cfg_err | r_proto_err | w_proto_now;
  assign w_dec_nxt = r_decerr | w_beat_oor_err;

  // Next beat address; INCR/WRAP advance from the size-aligned address
  assign w_step       = ADDR_WIDTH'(1) << r_size;
  assign w_aligned    = r_addr & ~(w_step - ADDR_WIDTH'(1));
  assign w_inc        = w_aligned + w_step;
  assign w_wrap_bytes = (ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size;
  assign w_wrap_mask  = w_wrap_bytes - ADDR_WIDTH'(1);
  assign w_wrap       = (w_aligned & ~w_wrap_mask) | (w_inc & w_wrap_mask);

  always_comb begin
    w_addr_nxt = r_addr;
    case (r_burst)
      BURST_FIXED: w_addr_nxt = r_addr;
      BURST_INCR:  w_addr_nxt = w_inc;
      BURST_WRAP:  w_addr_nxt = w_wrap;
      default:     w_addr_nxt = r_addr;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bid     <= w_bid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // Next-state logic computes the values the handshake outputs take after the edge
  always_comb begin
    w_state_nxt   = r_state;
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_bvalid_nxt  = 1'b0;
    w_bid_nxt     = r_bid;
    w_bresp_nxt   = r_bresp;
    case (r_state)
      S_IDLE: begin
        w_awready_nxt = 1'b1;
        if (w_aw_hs) begin
          w_state_nxt   = S_DATA;
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b1;
        end
      end
      S_DATA: begin
        w_wready_nxt = 1'b1;
        if (w_w_hs && axi_slv_wlast) begin
          w_state_nxt  = S_RESP;
          w_wready_nxt = 1'b0;
          w_bvalid_nxt = 1'b1;
          w_bid_nxt    = r_id;
          if (w_dec_nxt) begin
            w_bresp_nxt = RESP_DECERR;
          end else if (w_slv_nxt) begin
            w_bresp_nxt = RESP_SLVERR;
          end else begin
            w_bresp_nxt = RESP_OKAY;
          end
        end
      end
      S_RESP: begin
        w_bvalid_nxt = 1'b1;
        if (w_b_hs) begin
          w_state_nxt   = S_IDLE;
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Captured AW fields, beat counter, address walk and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_beat      <= '0;
      r_cfg_err   <= 1'b0;
      r_proto_err <= 1'b0;
      r_decerr    <= 1'b0;
      r_over      <= 1'b0;
    end else if (w_aw_hs) begin
      r_id        <= axi_slv_awid;
      r_addr      <= axi_slv_awaddr;
      r_len       <= axi_slv_awlen;
      r_size      <= axi_slv_awsize;
      r_burst     <= axi_slv_awburst;
      r_beat      <= '0;
      r_cfg_err   <= w_aw_cfg_err;
      r_proto_err <= 1'b0;
      r_decerr    <= 1'b0;
      r_over      <= 1'b0;
    end else if (w_w_hs) begin
      r_addr      <= w_addr_nxt;
      r_proto_err <= r_proto_err | w_proto_now;
      r_decerr    <= w_dec_nxt;
      // Counter stops at len; r_over then marks the trailing beats for discard
      if (!r_over && !w_beat_last) begin
        r_beat <= r_beat + LEN_WIDTH'(1);
      end
      if (w_beat_last) begin
        r_over <= 1'b1;
      end
    end
  end

  // Memory is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_beat_wr) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (axi_slv_wstrb[i]) begin
          r_mem[w_idx][i*8 +: 8] <= axi_slv_wdata[i*8 +: 8];
        end
      end
    end
  end

  assign dbg_rdata = r_mem[dbg_addr];

  assign axi_slv_awready = r_awready;
  assign axi_slv_wready  = r_wready;
  assign axi_slv_bvalid  = r_bvalid;
  assign axi_slv_bid     = r_bid;
  assign axi_slv_bresp   = r_bresp;

endmodule

// File: tb/tb_axi_wr_slv.sv
// tb_axi_wr_slv: directed bench for axi_wr_slv with a byte-level memory model,
// a response scoreboard and a per-cycle B-channel checker.
module tb_axi_wr_slv;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  always #5 clk = ~clk;

  axi_wr_slv #(
    .ID_WIDTH  (4),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .LEN_WIDTH (8),
    .MEM_DEPTH (256)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .axi_slv_awid   (awid),
    .axi_slv_awaddr (awaddr),
    .axi_slv_awlen  (awlen),
    .axi_slv_awsize (awsize),
    .axi_slv_awburst(awburst),
    .axi_slv_awvalid(awvalid),
    .axi_slv_awready(awready),
    .axi_slv_wdata  (wdata),
    .axi_slv_wstrb  (wstrb),
    .axi_slv_wlast  (wlast),
    .axi_slv_wvalid (wvalid),
    .axi_slv_wready (wready),
    .axi_slv_bid    (bid),
    .axi_slv_bresp  (bresp),
    .axi_slv_bvalid (bvalid),
    .axi_slv_bready (bready),
    .dbg_addr       (dbg_addr),
    .dbg_rdata      (dbg_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model memory with per-byte "known" mask (the DUT memory starts undefined)
  logic [31:0] mm    [256];
  logic [3:0]  kmask [256];
  logic [3:0]  eq_id   [$];
  logic [1:0]  eq_resp [$];
  logic [31:0] bd [16];
  logic [3:0]  bs [16];

  logic        b_active = 1'b0;
  logic [3:0]  b_hold_id;
  logic [1:0]  b_hold_resp;
  logic [1:0]  last_bresp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int l = 0; l < 4; l++) begin
      if (s[l]) begin
        mm[idx][l*8 +: 8] = d[l*8 +: 8];
        kmask[idx][l]     = 1'b1;
      end
    end
  endtask

  // Walk the burst with plain arithmetic and decide the response from the rules
  task automatic model_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] bt, input int nb, output logic [1:0] resp);
    longint a, al, wi, step, wb;
    bit cfg, dec, slv;
    step = longint'(1) << size;
    cfg  = (size > 3'd2) || (bt == 2'b11) ||
           ((bt == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    a    = longint'(addr);
    dec  = 1'b0;
    slv  = cfg;
    for (int b = 0; b < nb; b++) begin
      if (b <= int'(len)) begin
        wi = a / 4;
        if (wi >= 256) dec = 1'b1;
        else if (!cfg) model_write(int'(wi), bd[b], bs[b]);
        al = a - (a % step);
        if (bt == 2'b01) begin
          a = al + step;
        end else if (bt == 2'b10) begin
          wb = (longint'(len) + 1) * step;
          a  = (al / wb) * wb + (al + step) % wb;
        end
      end
    end
    if (nb != int'(len) + 1) slv = 1'b1;
    resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
  endtask

  task automatic check_mem();
    logic [31:0] m;
    for (int i = 0; i < 256; i++) begin
      if (kmask[i] != 4'h0) begin
        m = {{8{kmask[i][3]}}, {8{kmask[i][2]}}, {8{kmask[i][1]}}, {8{kmask[i][0]}}};
        dbg_addr = 8'(i);
        #1;
        check($sformatf("mem[%0d]", i), dbg_rdata & m, mm[i] & m);
      end
    end
  endtask

  task automatic mem_lit(input int idx, input logic [31:0] exp);
    dbg_addr = 8'(idx);
    #1;
    check($sformatf("mem_lit[%0d]", idx), dbg_rdata, exp);
  endtask

  // Per-cycle B channel checker: every new response is matched against the
  // scoreboard, and held responses must stay stable with AW/W closed.
  always @(negedge clk) begin
    if (rst) begin
      b_active = 1'b0;
    end else if (bvalid) begin
      if (!b_active) begin
        if (eq_id.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_b: got bvalid=1 (bid=0x%0h) expected no response", bid);
        end else begin
          check("bid", bid, eq_id.pop_front());
          check("bresp", bresp, eq_resp.pop_front());
        end
        b_hold_id   = bid;
        b_hold_resp = bresp;
        last_bresp  = bresp;
      end else begin
        check("bid_stable", bid, b_hold_id);
        check("bresp_stable", bresp, b_hold_resp);
      end
      check("awready_during_b", awready, 0);
      check("wready_during_b", wready, 0);
      b_active = !bready;
    end
  end

  task automatic burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input int nb,
                       input int bdelay, input logic [1:0] exp_lit);
    logic [1:0] mresp;
    int waited;
    model_burst(addr, len, size, bt, nb, mresp);
    eq_id.push_back(id);
    eq_resp.push_back(mresp);
    @(posedge clk);
    #1;
    if (bdelay > 0) bready = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = bt; awvalid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!awready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("awready_wait", waited, 0);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      wdata = bd[b]; wstrb = bs[b]; wlast = (b == nb - 1); wvalid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!wready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (b == 0) check("wready_after_aw", waited, 0);
      if (!wready) begin
        n_cmp++;
        n_err++;
        $display("FAIL w_timeout: got wready=0 expected 1 at beat %0d", b);
      end
      @(posedge clk);
      #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!bvalid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("bvalid_latency", waited, 0);
    if (bvalid) begin
      if (bdelay > 0) begin
        repeat (bdelay - 1) @(negedge clk);
        @(posedge clk);
        #1;
        bready = 1'b1;
        @(negedge clk);
      end
      @(negedge clk);
      check("bvalid_after_hs", bvalid, 0);
      check("awready_after_hs", awready, 1);
      check("bresp_literal", last_bresp, exp_lit);
    end
    check_mem();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mm[i]    = '0;
      kmask[i] = '0;
    end
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1; dbg_addr = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_bid", bid, 0);
    check("rst_bresp", bresp, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("awready_before_first_edge", awready, 0);
    @(negedge clk);
    check("awready_first_cycle", awready, 1);

    // INCR 4 beats
    for (int i = 0; i < 4; i++) begin bd[i] = 32'hA0 + 32'(i); bs[i] = 4'hF; end
    burst(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, 4, 0, 2'b00);
    mem_lit(4, 32'hA0);
    mem_lit(7, 32'hA3);

    // WRAP 4 beats starting mid-window
    for (int i = 0; i < 4; i++) begin bd[i] = 32'hB0 + 32'(i); bs[i] = 4'hF; end
    burst(4'h6, 32'h38, 8'd3, 3'd2, 2'b10, 4, 0, 2'b00);
    mem_lit(14, 32'hB0);
    mem_lit(15, 32'hB1);
    mem_lit(12, 32'hB2);
    mem_lit(13, 32'hB3);

    // FIXED with complementary strobes
    bd[0] = 32'h1111_2222; bs[0] = 4'h3;
    bd[1] = 32'h3333_4444; bs[1] = 4'hC;
    burst(4'h7, 32'h20, 8'd1, 3'd2, 2'b00, 2, 0, 2'b00);
    mem_lit(8, 32'h3333_2222);

    // Single beat, minimum latency
    bd[0] = 32'h5555_AAAA; bs[0] = 4'hF;
    burst(4'hA, 32'h40, 8'd0, 3'd2, 2'b01, 1, 0, 2'b00);
    mem_lit(16, 32'h5555_AAAA);

    // Second beat runs past the last word
    bd[0] = 32'hC0; bs[0] = 4'hF;
    bd[1] = 32'hC1; bs[1] = 4'hF;
    burst(4'h1, 32'h3FC, 8'd1, 3'd2, 2'b01, 2, 0, 2'b11);
    mem_lit(255, 32'hC0);

    // Early wlast on beat 2 of 4
    bd[0] = 32'hD0; bs[0] = 4'hF;
    bd[1] = 32'hD1; bs[1] = 4'hF;
    burst(4'h2, 32'h60, 8'd3, 3'd2, 2'b01, 2, 0, 2'b10);
    mem_lit(24, 32'hD0);
    mem_lit(25, 32'hD1);

    // Reserved burst type: nothing written
    bd[0] = 32'hE0; bs[0] = 4'hF;
    burst(4'h3, 32'h10, 8'd0, 3'd2, 2'b11, 1, 0, 2'b10);
    mem_lit(4, 32'hA0);

    // Missing wlast on beat len: extra beat discarded
    bd[0] = 32'h70; bs[0] = 4'hF;
    bd[1] = 32'h71; bs[1] = 4'hF;
    bd[2] = 32'h72; bs[2] = 4'hF;
    burst(4'h4, 32'h70, 8'd1, 3'd2, 2'b01, 3, 0, 2'b10);

    // B backpressure for 5 cycles, sparse strobes
    bd[0] = 32'h1234_5678; bs[0] = 4'h5;
    burst(4'h9, 32'h90, 8'd0, 3'd2, 2'b01, 1, 5, 2'b00);

    // W presented before AW must not be accepted
    @(posedge clk);
    #1;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wready_idle", wready, 0);
    end
    @(posedge clk);
    #1;
    wvalid = 1'b0; wlast = 1'b0;
    check_mem();

    // Unaligned start address
    bd[0] = 32'hF0F1_F2F3; bs[0] = 4'hC;
    bd[1] = 32'h0102_0304; bs[1] = 4'hF;
    burst(4'hB, 32'hA2, 8'd1, 3'd2, 2'b01, 2, 0, 2'b00);
    mem_lit(41, 32'h0102_0304);

    // Known contents for the reset-abort target
    for (int i = 0; i < 4; i++) begin bd[i] = 32'h11 + 32'(i); bs[i] = 4'hF; end
    burst(4'h8, 32'h80, 8'd3, 3'd2, 2'b01, 4, 0, 2'b00);

    // Reset asserted while beat 2 of 4 is on the bus
    @(posedge clk);
    #1;
    awid = 4'h6; awaddr = 32'h80; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    check("abort_awready", awready, 1);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wdata = 32'hEE0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(negedge clk);
    check("abort_wready", wready, 1);
    @(posedge clk);
    #1;
    wdata = 32'hEE1;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    wvalid = 1'b0;
    @(negedge clk);
    check("abort_awready_rst", awready, 0);
    check("abort_wready_rst", wready, 0);
    check("abort_bvalid_rst", bvalid, 0);
    check("abort_bid_rst", bid, 0);
    check("abort_bresp_rst", bresp, 0);
    model_write(32, 32'hEE0, 4'hF);
    repeat (8) @(negedge clk);
    check("abort_no_b", bvalid, 0);
    check_mem();
    mem_lit(32, 32'hEE0);
    mem_lit(33, 32'h12);

    // Clean burst after the abort
    for (int i = 0; i < 4; i++) begin bd[i] = 32'h21 + 32'(i); bs[i] = 4'hF; end
    burst(4'hC, 32'hC0, 8'd3, 3'd2, 2'b01, 4, 0, 2'b00);
    mem_lit(48, 32'h21);

    repeat (4) @(negedge clk);
    check("responses_outstanding", eq_id.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
